// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and default parameters shared by the fetch unit and its queue.
package fetch_pkg;
  typedef enum logic [1:0] {RUN, WAIT_RSP, DRAIN} fetch_state_e;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INST_W   = 32;
  localparam int DEF_QDEPTH   = 4;
  localparam int DEF_RESET_PC = 0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered instruction queue with flush; head reads as zero when empty.
module fetch_fifo import fetch_pkg::*; #(
  parameter int W     = DEF_ADDR_W + DEF_INST_W,
  parameter int DEPTH = DEF_QDEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [W-1:0]             data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    valid   = cnt_q != '0;
    data    = valid ? mem_q[rd_q] : '0;
    count   = cnt_q;
    do_push = push && cnt_q != (AW+1)'(DEPTH);
    do_pop  = pop && valid;
    wr_d    = flush ? '0 : wr_q + AW'(do_push);
    rd_d    = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d   = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with redirect handling and an output queue.
module fetch_unit import fetch_pkg::*; #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                QDEPTH   = DEF_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);
  localparam int INST_B = INST_W / 8;
  localparam int CW     = $clog2(QDEPTH) + 1;
  fetch_state_e                state_q, state_d;
  logic [ADDR_W-1:0]           pc_q, pc_d, req_pc_q, req_pc_d;
  logic [CW-1:0]               count;
  logic [ADDR_W+INST_W-1:0]    q_data;
  logic                        acc, push, pop, rsp_take;
  always_comb begin
    imem_req_valid = !reset && !redirect_valid && state_q == RUN && count < CW'(QDEPTH);
    imem_req_addr  = pc_q;
    acc            = imem_req_valid && imem_req_ready;
    pop            = out_valid && out_ready;
    push           = !redirect_valid && state_q == WAIT_RSP && imem_rsp_valid;
    rsp_take       = imem_rsp_valid && state_q != RUN;
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    // A response coinciding with the redirect is the one being drained, so no DRAIN is needed
    if (redirect_valid) begin
      state_d = (state_q != RUN && !imem_rsp_valid) ? DRAIN : RUN;
      pc_d    = redirect_target & ~ADDR_W'(INST_B - 1);
    end else if (acc) begin
      state_d  = WAIT_RSP;
      pc_d     = pc_q + ADDR_W'(INST_B);
      req_pc_d = pc_q;
    end else if (rsp_take) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end
  fetch_fifo #(.W(ADDR_W + INST_W), .DEPTH(QDEPTH)) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc_q, imem_rsp_data}),
    .pop       (pop),
    .valid     (out_valid),
    .data      (q_data),
    .count     (count)
  );
  assign out_pc   = q_data[ADDR_W+INST_W-1:INST_W];
  assign out_inst = q_data[INST_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle-by-cycle vector table plus hand sequences for reset and 16-bit wrap.
module tb_fetch_unit;
  typedef struct {
    logic rst, rdy, rv;
    logic [31:0] rd;
    logic redir;
    logic [31:0] tgt;
    logic ordy, e_rqv;
    logic [31:0] e_a;
    logic e_ov;
    logic [31:0] e_pc;
  } vec_t;

  logic clk = 0, rst = 1;
  logic rdy = 0, rv = 0, redir = 0, ordy = 0;
  logic [31:0] rd = 0, tgt = 0;
  logic rqv, ov;
  logic [31:0] addr, inst, opc;

  logic s_rst = 1, s_rdy = 0, s_rv = 0, s_redir = 0, s_ordy = 0;
  logic [31:0] s_rd = 0;
  logic [15:0] s_tgt = 0, s_addr, s_pc;
  logic s_rqv, s_ov;
  logic [31:0] s_inst;

  int n_tests = 0, n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clock(clk), .reset(rst),
    .imem_req_valid(rqv), .imem_req_addr(addr), .imem_req_ready(rdy),
    .imem_rsp_valid(rv), .imem_rsp_data(32'hC0DE_0000 | rd),
    .redirect_valid(redir), .redirect_target(tgt),
    .out_valid(ov), .out_inst(inst), .out_pc(opc), .out_ready(ordy)
  );

  fetch_unit #(.ADDR_W(16)) u16 (
    .clock(clk), .reset(s_rst),
    .imem_req_valid(s_rqv), .imem_req_addr(s_addr), .imem_req_ready(s_rdy),
    .imem_rsp_valid(s_rv), .imem_rsp_data(32'hC0DE_0000 | s_rd),
    .redirect_valid(s_redir), .redirect_target(s_tgt),
    .out_valid(s_ov), .out_inst(s_inst), .out_pc(s_pc), .out_ready(s_ordy)
  );

  function automatic vec_t v(input logic r, y, q, input logic [31:0] d, input logic x,
                             input logic [31:0] t, input logic o, e, input logic [31:0] a,
                             input logic eo, input logic [31:0] p);
    v = '{r, y, q, d, x, t, o, e, a, eo, p};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // rst rdy rv rd redir tgt ordy | req_valid addr out_valid out_pc
    tbl.push_back(v(1,0,0,0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,4,1,0));
    tbl.push_back(v(0,1,1,4,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,8,1,4));
    tbl.push_back(v(0,1,1,8,0,0,1, 0,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0, 0,0,1,8));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,4,1,0));
    tbl.push_back(v(0,1,1,4,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,8,1,0));
    tbl.push_back(v(0,1,1,8,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,12,1,0));
    tbl.push_back(v(0,1,1,12,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,16,1,4));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,16,1,8));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,16,1,12));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,16,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,16,0,0));
    tbl.push_back(v(0,1,0,0,1,'h103,1, 0,0,0,0));
    tbl.push_back(v(0,1,1,16,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,'h100,0,0));
    tbl.push_back(v(0,1,1,'h100,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,'h104,1,'h100));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,'h104,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,'h104,0,0));
    tbl.push_back(v(0,1,1,'h104,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,'h108,1,'h104));
    tbl.push_back(v(0,1,0,0,1,'h200,0, 0,0,1,'h104));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,'h200,0,0));
    tbl.push_back(v(0,1,1,'h200,1,'h300,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,'h999,0,0,0, 1,'h300,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0, 1,'h300,0,0));
    tbl.push_back(v(0,1,1,'h300,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,'h304,1,'h300));
    tbl.push_back(v(0,1,0,0,0,0,1, 1,'h304,0,0));
    tbl.push_back(v(0,1,0,0,1,'h400,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,1,'h502,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,1,'h777,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1, 1,'h500,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; rdy = tbl[i].rdy; rv = tbl[i].rv; rd = tbl[i].rd;
      redir = tbl[i].redir; tgt = tbl[i].tgt; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d req_valid", i), 32'(rqv), 32'(tbl[i].e_rqv));
      if (tbl[i].e_rqv) chk($sformatf("v%0d req_addr", i), addr, tbl[i].e_a);
      chk($sformatf("v%0d out_valid", i), 32'(ov), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d out_pc", i), opc, tbl[i].e_pc);
        chk($sformatf("v%0d out_inst", i), inst, 32'hC0DE_0000 | tbl[i].e_pc);
      end
    end

    // reset during WAIT_RSP, late response right after reset
    @(negedge clk); rdy = 1; rv = 0; redir = 0; ordy = 0; #1;
    chk("rw accept addr", addr, 32'h500);
    @(negedge clk); rst = 1; rdy = 0; #1;
    chk("rw req_valid in reset", 32'(rqv), 0);
    @(negedge clk); rst = 0; rv = 1; rd = 32'h500; #1;
    chk("rw req_valid after reset", 32'(rqv), 1);
    chk("rw req_addr after reset", addr, 32'h0);
    chk("rw out_valid after reset", 32'(ov), 0);
    chk("rw out_pc after reset", opc, 0);
    chk("rw out_inst after reset", inst, 0);
    @(negedge clk); rv = 0; rdy = 1; #1;
    chk("rw late rsp dropped", 32'(ov), 0);
    @(negedge clk); rdy = 0; rv = 1; rd = 0; #1;
    chk("rw wait req_valid", 32'(rqv), 0);
    @(negedge clk); rv = 0; #1;
    chk("rw first out_valid", 32'(ov), 1);
    chk("rw first out_pc", opc, 32'h0);
    chk("rw first out_inst", inst, 32'hC0DE_0000);

    // 16-bit address wrap
    @(negedge clk); s_rst = 0; s_redir = 1; s_tgt = 16'hFFFC; #1;
    chk("w16 req_valid under redirect", 32'(s_rqv), 0);
    @(negedge clk); s_redir = 0; s_rdy = 1; #1;
    chk("w16 req_addr", 32'(s_addr), 32'hFFFC);
    @(negedge clk); s_rdy = 0; s_rv = 1; s_rd = 32'hFFFC; #1;
    chk("w16 wait req_valid", 32'(s_rqv), 0);
    @(negedge clk); s_rv = 0; s_rdy = 1; s_ordy = 1; #1;
    chk("w16 wrapped req_addr", 32'(s_addr), 32'h0);
    chk("w16 out_valid", 32'(s_ov), 1);
    chk("w16 out_pc", 32'(s_pc), 32'hFFFC);
    chk("w16 out_inst", s_inst, 32'hC0DE_FFFC);
    @(negedge clk); s_rdy = 0; s_rv = 1; s_rd = 0; #1;
    chk("w16 popped", 32'(s_ov), 0);
    @(negedge clk); s_rv = 0; #1;
    chk("w16 out_valid 2", 32'(s_ov), 1);
    chk("w16 out_pc 2", 32'(s_pc), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
